// File: rtl/baser_pkg.sv
// Shared types and default timing for the 10GBASE-R link bring-up controller.
package baser_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_PLL  = 3'd0,
        ST_PCS_RESET = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_LINK_UP   = 3'd4
    } link_state_e;

    localparam int unsigned PLL_STABLE_DEF    = 64;
    localparam int unsigned RST_CYCLES_DEF    = 32;
    localparam int unsigned LOCK_TIMEOUT_DEF  = 100000;
    localparam int unsigned STABLE_CYCLES_DEF = 1024;

    localparam int unsigned RETRY_W = 8;
    localparam int unsigned DROP_W  = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/baser_link_ctrl.sv
// Link bring-up sequencer: waits for PLL, pulses PCS reset, qualifies block lock, gates TX.
module baser_link_ctrl
    import baser_pkg::*;
#(
    parameter int unsigned PLL_STABLE    = PLL_STABLE_DEF,
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                 clk_156,
    input  logic                 rst_156_n,
    input  logic                 pll_locked,
    input  logic                 block_lock,
    input  logic                 hi_ber,
    input  logic                 restart,
    output logic                 pcs_rst,
    output logic                 tx_en,
    output logic                 link_up,
    output logic [2:0]           state_o,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int unsigned TMR_W =
        $clog2(max_u(max_u(PLL_STABLE, RST_CYCLES), max_u(LOCK_TIMEOUT, STABLE_CYCLES))) + 1;

    logic pll_locked_s;
    logic block_lock_s;
    logic hi_ber_s;
    logic good;

    link_state_e        state_q;
    link_state_e        state_d;
    logic [TMR_W-1:0]   timer_q;
    logic               timer_clr;
    logic               retry_inc;
    logic               drop_inc;

    sync_2ff u_sync_pll (.clk(clk_156), .rst_n(rst_156_n), .d(pll_locked), .q(pll_locked_s));
    sync_2ff u_sync_blk (.clk(clk_156), .rst_n(rst_156_n), .d(block_lock), .q(block_lock_s));
    sync_2ff u_sync_ber (.clk(clk_156), .rst_n(rst_156_n), .d(hi_ber),     .q(hi_ber_s));

    assign good    = block_lock_s & ~hi_ber_s;
    assign state_o = state_q;

    // Next-state: PLL loss beats restart, which beats the per-state rules.
    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        retry_inc = 1'b0;
        drop_inc  = 1'b0;

        if ((state_q != ST_WAIT_PLL) && !pll_locked_s) begin
            state_d = ST_WAIT_PLL;
        end else if (restart) begin
            state_d = ST_PCS_RESET;
        end else begin
            case (state_q)
                ST_WAIT_PLL: begin
                    if (!pll_locked_s) begin
                        timer_clr = 1'b1;
                    end else if (timer_q == TMR_W'(PLL_STABLE - 1)) begin
                        state_d = ST_PCS_RESET;
                    end
                end
                ST_PCS_RESET: begin
                    if (timer_q == TMR_W'(RST_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (good) begin
                        state_d = ST_STABLE;
                    end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        state_d   = ST_PCS_RESET;
                        retry_inc = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!good) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_LINK_UP;
                    end
                end
                ST_LINK_UP: begin
                    if (!good) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                default: begin
                    state_d = ST_WAIT_PLL;
                end
            endcase
        end

        // A restart into PCS_RESET while already there re-arms the full pulse.
        if ((state_d != state_q) || restart) begin
            timer_clr = 1'b1;
        end
        if ((state_q == ST_LINK_UP) && (state_d != ST_LINK_UP)) begin
            drop_inc = 1'b1;
        end
    end

    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) begin
            state_q <= ST_WAIT_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    // Shared timer saturates rather than wrapping while parked in LINK_UP.
    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) begin
            timer_q <= '0;
        end else if (timer_clr) begin
            timer_q <= '0;
        end else if (timer_q != '1) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) begin
            retry_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (retry_inc && (retry_cnt != '1)) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
            if (drop_inc && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    // Outputs registered from the next state so they line up with state_o.
    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) begin
            pcs_rst <= 1'b1;
            tx_en   <= 1'b0;
            link_up <= 1'b0;
        end else begin
            pcs_rst <= (state_d == ST_WAIT_PLL) || (state_d == ST_PCS_RESET);
            tx_en   <= (state_d == ST_LINK_UP);
            link_up <= (state_d == ST_LINK_UP);
        end
    end

endmodule
